state_round_ctrl: RTL and testbench

Sequencer for the 256-bit cipher/hash state register. It accepts a message block over a valid/ready handshake and loads the state as IV ^ block. It then iterates an external combinational round function for ROUNDS cycles and presents the result over a valid/ready output handshake. It sits between the block-input interface and the round datapath, and owns the state register's enable, clear and load sequencing.

---
 rtl/state_round_pkg.sv | 15 +
 rtl/src_state_reg.sv | 37 +++
 rtl/state_round_ctrl.sv | 104 ++++++++++
 tb/tb_state_round_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/state_round_pkg.sv
// Shared types and constants for the state/round sequencer.
package state_round_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} src_state_t;

    localparam logic [255:0] IV_DEFAULT = {4{64'h0412_6424_0034_3C28}};

    // Round index width: enough bits for 0..ROUNDS-1, never narrower than one bit.
    function automatic int rnd_w(input int rounds);
        int w;
        w = $clog2(rounds);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/src_state_reg.sv
// State register: IV at reset, IV ^ d_load on load, round result otherwise.
module src_state_reg
    import state_round_pkg::*;
#(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] IV    = WIDTH'(IV_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d_load,
    input  logic [WIDTH-1:0] d_round,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Select the next state value: whitened load, round result, or hold.
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (load) state_d = IV ^ d_load;
            else      state_d = d_round;
        end
    end

    // State flop with synchronous reset to IV.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IV;
        else       state_q <= state_d;
    end

    assign q = state_q;

endmodule

// File: rtl/state_round_ctrl.sv
// Sequencer: loads IV ^ block, runs ROUNDS iterations, presents the result.
module state_round_ctrl
    import state_round_pkg::*;
#(
    parameter int               WIDTH  = 256,
    parameter int               ROUNDS = 10,
    parameter logic [WIDTH-1:0] IV     = WIDTH'(IV_DEFAULT),
    localparam int              RW     = rnd_w(ROUNDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_block,
    output logic [WIDTH-1:0] rnd_in,
    output logic [RW-1:0]    rnd_idx,
    input  logic [WIDTH-1:0] rnd_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    src_state_t       fsm_q, fsm_d;
    logic [RW-1:0]    idx_q, idx_d;
    logic             load_fire;
    logic             reg_en;
    logic             reg_load;
    logic [WIDTH-1:0] reg_d_load;
    logic [WIDTH-1:0] state;

    // Flush wins over an input handshake, so a block offered with flush is dropped.
    assign load_fire  = in_valid && (fsm_q == IDLE) && !flush;
    assign reg_en     = load_fire || (fsm_q == RUN) || flush;
    assign reg_load   = load_fire || flush;
    assign reg_d_load = flush ? '0 : in_block;

    // Next-state and round counter logic.
    always_comb begin
        fsm_d = fsm_q;
        idx_d = idx_q;
        if (flush) begin
            fsm_d = IDLE;
            idx_d = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        fsm_d = RUN;
                        idx_d = '0;
                    end
                end
                RUN: begin
                    if (idx_q == RW'(ROUNDS - 1)) begin
                        fsm_d = DONE;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) fsm_d = IDLE;
                end
                default: begin
                    fsm_d = IDLE;
                    idx_d = '0;
                end
            endcase
        end
    end

    // FSM and round index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= IDLE;
            idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
        end
    end

    src_state_reg #(
        .WIDTH (WIDTH),
        .IV    (IV)
    ) u_state_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (reg_en),
        .load    (reg_load),
        .d_load  (reg_d_load),
        .d_round (rnd_out),
        .q       (state)
    );

    assign rnd_in    = state;
    assign out_data  = state;
    assign rnd_idx   = idx_q;
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN) || (fsm_q == DONE);

endmodule

// File: tb/tb_state_round_ctrl.sv
// Directed bench for state_round_ctrl: ROUNDS=10 and ROUNDS=1 instances.
module tb_state_round_ctrl;

    localparam logic [255:0] IV = {4{64'h0412_6424_0034_3C28}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // ROUNDS=10 instance
    logic         flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic         in_ready_a, out_valid_a, busy_a;
    logic [255:0] in_block_a = '0, rnd_in_a, rnd_out_a, out_data_a;
    logic [3:0]   rnd_idx_a;
    logic         xor_mode = 1'b0;

    assign rnd_out_a = xor_mode ? (rnd_in_a ^ 256'(rnd_idx_a)) : (rnd_in_a + 256'd1);

    state_round_ctrl #(.WIDTH(256), .ROUNDS(10), .IV(IV)) u_a (
        .clk(clk), .reset(reset), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_block(in_block_a),
        .rnd_in(rnd_in_a), .rnd_idx(rnd_idx_a), .rnd_out(rnd_out_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .busy(busy_a)
    );

    // ROUNDS=1 instance
    logic         flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [255:0] in_block_b = '0, rnd_in_b, rnd_out_b, out_data_b;
    logic [0:0]   rnd_idx_b;

    assign rnd_out_b = rnd_in_b + 256'd1;

    state_round_ctrl #(.WIDTH(256), .ROUNDS(1), .IV(IV)) u_b (
        .clk(clk), .reset(reset), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
        .rnd_in(rnd_in_b), .rnd_idx(rnd_idx_b), .rnd_out(rnd_out_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready_a); end
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
        n_checks++; if (rnd_idx_a !== 4'd0) begin n_fail++; $display("FAIL reset_rnd_idx: got %0d want 0", rnd_idx_a); end
        n_checks++; if (out_data_a !== IV) begin n_fail++; $display("FAIL reset_state: got %h want %h", out_data_a, IV); end
        n_checks++; if (out_data_b !== IV) begin n_fail++; $display("FAIL reset_state_r1: got %h want %h", out_data_b, IV); end
        n_checks++; if (in_ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_r1: got %0b want 1", in_ready_b); end
    endtask

    task automatic test_single_block();
        xor_mode    = 1'b0;
        out_ready_a = 1'b1;
        in_block_a  = '0;
        in_valid_a  = 1'b1;
        tick();
        in_valid_a  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (rnd_idx_a !== 4'(k)) begin n_fail++; $display("FAIL single_rnd_idx: cycle %0d got %0d want %0d", k, rnd_idx_a, k); end
            n_checks++; if (out_valid_a !== 1'b0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL single_run_flags: cycle %0d got ov=%0b busy=%0b want ov=0 busy=1", k, out_valid_a, busy_a); end
            n_checks++; if (rnd_in_a !== IV + 256'(k)) begin n_fail++; $display("FAIL single_rnd_in: cycle %0d got %h want %h", k, rnd_in_a, IV + 256'(k)); end
            tick();
        end
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL single_latency: got out_valid %0b want 1", out_valid_a); end
        n_checks++; if (out_data_a !== IV + 256'd10) begin n_fail++; $display("FAIL single_data: got %h want %h", out_data_a, IV + 256'd10); end
        n_checks++; if (rnd_idx_a !== 4'd0 || in_ready_a !== 1'b0) begin n_fail++; $display("FAIL single_done_flags: got idx=%0d in_ready=%0b want idx=0 in_ready=0", rnd_idx_a, in_ready_a); end
        tick();
        n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL single_release: got ov=%0b in_ready=%0b want ov=0 in_ready=1", out_valid_a, in_ready_a); end
        n_checks++; if (out_data_a !== IV + 256'd10) begin n_fail++; $display("FAIL single_hold_idle: got %h want %h", out_data_a, IV + 256'd10); end
    endtask

    task automatic test_whitening();
        xor_mode    = 1'b1;
        out_ready_a = 1'b1;
        in_block_a  = IV;
        in_valid_a  = 1'b1;
        tick();
        in_valid_a  = 1'b0;
        n_checks++; if (rnd_in_a !== 256'd0) begin n_fail++; $display("FAIL whiten_load: got %h want 0", rnd_in_a); end
        for (int k = 0; k < 10; k++) tick();
        n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== 256'd1) begin n_fail++; $display("FAIL whiten_result: got ov=%0b data=%h want ov=1 data=1", out_valid_a, out_data_a); end
        tick();
        xor_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [255:0] b1, b2;
        b1 = {4{64'hDEAD_BEEF_0123_4567}};
        b2 = {4{64'h0F0F_F0F0_1234_ABCD}};
        out_ready_a = 1'b0;
        in_block_a  = b1;
        in_valid_a  = 1'b1;
        tick();
        in_block_a  = b2;
        for (int k = 0; k < 10; k++) tick();
        for (int k = 0; k < 20; k++) begin
            n_checks++; if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_flags: cycle %0d got ov=%0b in_ready=%0b want ov=1 in_ready=0", k, out_valid_a, in_ready_a); end
            n_checks++; if (out_data_a !== (IV ^ b1) + 256'd10) begin n_fail++; $display("FAIL bp_data: cycle %0d got %h want %h", k, out_data_a, (IV ^ b1) + 256'd10); end
            tick();
        end
        out_ready_a = 1'b1;
        tick();
        n_checks++; if (busy_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_release: got busy=%0b in_ready=%0b want busy=0 in_ready=1", busy_a, in_ready_a); end
        tick();
        in_valid_a = 1'b0;
        n_checks++; if (busy_a !== 1'b1 || rnd_in_a !== (IV ^ b2)) begin n_fail++; $display("FAIL bp_next_load: got busy=%0b state=%h want busy=1 state=%h", busy_a, rnd_in_a, IV ^ b2); end
        for (int k = 0; k < 10; k++) tick();
        n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== (IV ^ b2) + 256'd10) begin n_fail++; $display("FAIL bp_next_data: got ov=%0b data=%h want ov=1 data=%h", out_valid_a, out_data_a, (IV ^ b2) + 256'd10); end
        tick();
    endtask

    task automatic test_flush();
        int           seen;
        logic [255:0] b3, b4;
        b3 = 256'h1234_5678;
        b4 = {64'h1, 64'h2, 64'h3, 64'h4};
        out_ready_a = 1'b1;
        in_block_a  = b3;
        in_valid_a  = 1'b1;
        tick();
        in_valid_a  = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++; if (rnd_idx_a !== 4'd4) begin n_fail++; $display("FAIL flush_pre_idx: got %0d want 4", rnd_idx_a); end
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        n_checks++; if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got in_ready=%0b busy=%0b want 1 0", in_ready_a, busy_a); end
        n_checks++; if (rnd_in_a !== IV || rnd_idx_a !== 4'd0) begin n_fail++; $display("FAIL flush_state: got state=%h idx=%0d want state=%h idx=0", rnd_in_a, rnd_idx_a, IV); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid_a === 1'b1) seen++;
            tick();
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_output: got %0d out_valid cycles want 0", seen); end
        // a block offered together with flush in IDLE must not be taken
        in_block_a = b4;
        in_valid_a = 1'b1;
        flush_a    = 1'b1;
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready: got %0b want 1", in_ready_a); end
        tick();
        flush_a = 1'b0;
        n_checks++; if (busy_a !== 1'b0 || rnd_in_a !== IV) begin n_fail++; $display("FAIL flush_reject: got busy=%0b state=%h want busy=0 state=%h", busy_a, rnd_in_a, IV); end
        tick();
        in_valid_a = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== (IV ^ b4) + 256'd10) begin n_fail++; $display("FAIL flush_resume: got ov=%0b data=%h want ov=1 data=%h", out_valid_a, out_data_a, (IV ^ b4) + 256'd10); end
        tick();
    endtask

    task automatic test_reset_in_done();
        logic [255:0] b5;
        b5 = 256'hA5A5_5A5A;
        out_ready_a = 1'b0;
        in_block_a  = b5;
        in_valid_a  = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) tick();
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL rst_pre_done: got out_valid %0b want 1", out_valid_a); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || rnd_in_a !== IV) begin n_fail++; $display("FAIL rst_done: got ov=%0b busy=%0b state=%h want ov=0 busy=0 state=%h", out_valid_a, busy_a, rnd_in_a, IV); end
        tick();
        in_valid_a = 1'b0;
        n_checks++; if (busy_a !== 1'b1 || rnd_in_a !== (IV ^ b5)) begin n_fail++; $display("FAIL rst_next_accept: got busy=%0b state=%h want busy=1 state=%h", busy_a, rnd_in_a, IV ^ b5); end
        for (int k = 0; k < 10; k++) tick();
        out_ready_a = 1'b1;
        n_checks++; if (out_data_a !== (IV ^ b5) + 256'd10) begin n_fail++; $display("FAIL rst_next_data: got %h want %h", out_data_a, (IV ^ b5) + 256'd10); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [255:0] blk [4];
        blk[0] = '0;
        blk[1] = {256{1'b1}};
        blk[2] = 256'hCAFE;
        blk[3] = {128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0001};
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_block_b = blk[i];
            tick();
            n_checks++; if (busy_b !== 1'b1 || out_valid_b !== 1'b0 || rnd_idx_b !== 1'b0) begin n_fail++; $display("FAIL b2b_run: blk %0d got busy=%0b ov=%0b idx=%0d want 1 0 0", i, busy_b, out_valid_b, rnd_idx_b); end
            tick();
            n_checks++; if (out_valid_b !== 1'b1 || out_data_b !== (IV ^ blk[i]) + 256'd1) begin n_fail++; $display("FAIL b2b_data: blk %0d got ov=%0b data=%h want ov=1 data=%h", i, out_valid_b, out_data_b, (IV ^ blk[i]) + 256'd1); end
            tick();
            n_checks++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: blk %0d got ov=%0b in_ready=%0b want 0 1", i, out_valid_b, in_ready_b); end
        end
        in_valid_b = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_block();
        test_whitening();
        test_backpressure();
        test_flush();
        test_reset_in_done();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
